// File: rtl/obstacle_scroller.sv
// Obstacle generator for the T-Rex game: NUM_OB channels scroll round a circular track and drive a scanned LED matrix.
// Latency: ob_pos/ob_type/step_tick/fast_mode are register outputs; row/col follow a slot or position change by 1 cycle.
// Backpressure: none; pause holds the step divider while the LFSR and the display scan keep running.
//
// Ports:
//   clk          system clock
//   flag_restart synchronous active-high restart; beats every other event in the same cycle
//   pause        1 = freeze scrolling (step divider holds)
//   row          row drive, active high, for the obstacle in the current scan slot
//   col          column drive, active low (0 = lit)
//   ob_pos       packed positions, channel i at [8i+7:8i]
//   ob_type      packed types, channel i at [2i+1:2i]
//   step_tick    one-cycle pulse coincident with each position update
//   fast_mode    1 once LEVEL_STEPS steps have been taken since restart
module obstacle_scroller #(
    parameter int          DISP_W      = 16,
    parameter int          DISP_H      = 8,
    parameter int          TRACK_LEN   = 51,
    parameter int          NUM_OB      = 3,
    parameter int          FIRST_POS   = 13,
    parameter int          SPACING     = 11,
    parameter int          STEP_SLOW   = 12500000,
    parameter int          STEP_FAST   = 10000000,
    parameter int          LEVEL_STEPS = 40,
    parameter int          SCAN_DIV    = 500,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  flag_restart,
    input  logic                  pause,
    output logic [DISP_H-1:0]     row,
    output logic [DISP_W-1:0]     col,
    output logic [NUM_OB*8-1:0]   ob_pos,
    output logic [NUM_OB*2-1:0]   ob_type,
    output logic                  step_tick,
    output logic                  fast_mode
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int STEP_MAX = (STEP_SLOW > STEP_FAST) ? STEP_SLOW : STEP_FAST;
    localparam int DIV_W    = $clog2(STEP_MAX + 1);
    localparam int CNT_W    = $clog2(LEVEL_STEPS + 1) > 0 ? $clog2(LEVEL_STEPS + 1) : 1;
    localparam int SCAN_W   = $clog2(SCAN_DIV + 1);
    localparam int SLOT_W   = (NUM_OB > 1) ? $clog2(NUM_OB) : 1;

    localparam logic [DIV_W-1:0]  SLOW_LAST = DIV_W'(STEP_SLOW - 1);
    localparam logic [DIV_W-1:0]  FAST_LAST = DIV_W'(STEP_FAST - 1);
    localparam logic [CNT_W-1:0]  LEVEL_CNT = CNT_W'(LEVEL_STEPS);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_OB - 1);
    localparam logic [7:0]        POS_LAST  = 8'(TRACK_LEN - 1);

    // Obstacle type encoding
    localparam logic [1:0] T_BOX       = 2'd0;
    localparam logic [1:0] T_POST      = 2'd1;
    localparam logic [1:0] T_HIGH_BIRD = 2'd2;
    localparam logic [1:0] T_LOW_BIRD  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]        pos_q  [NUM_OB];
    logic [7:0]        pos_d  [NUM_OB];
    logic [1:0]        type_q [NUM_OB];
    logic [1:0]        type_d [NUM_OB];

    logic [15:0]       lfsr_q,     lfsr_d;
    logic [DIV_W-1:0]  div_q,      div_d;
    logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
    logic              fast_q,     fast_d;
    logic              tick_q,     tick_d;
    logic [SCAN_W-1:0] scan_q,     scan_d;
    logic [SLOT_W-1:0] slot_q,     slot_d;
    logic [DISP_H-1:0] row_q,      row_d;
    logic [DISP_W-1:0] col_q,      col_d;

    logic              step_now;
    logic [DIV_W-1:0]  period_last;

    // ------------------------------------------------------------------
    // LFSR: 16-bit Fibonacci, taps 16,14,13,11 (bits 15,13,12,10)
    // ------------------------------------------------------------------
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // ------------------------------------------------------------------
    // Step divider. The period is chosen from the registered mode, so a
    // mode change made at a step edge only affects the following period.
    // ------------------------------------------------------------------
    always_comb begin
        period_last = fast_q ? FAST_LAST : SLOW_LAST;
        step_now    = 1'b0;
        div_d       = div_q;
        if (!pause) begin
            // >= rather than == so a stale count can never run away
            if (div_q >= period_last) begin
                div_d    = '0;
                step_now = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Level tracking
    // ------------------------------------------------------------------
    always_comb begin
        step_cnt_d = step_cnt_q;
        fast_d     = fast_q;
        tick_d     = step_now;
        if (step_now && (step_cnt_q != LEVEL_CNT)) begin
            step_cnt_d = step_cnt_q + 1'b1;
        end
        if (step_now && (step_cnt_d == LEVEL_CNT)) begin
            fast_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Obstacle movement. All channels wrapping on the same step share the
    // same respawn type because they all sample the same LFSR state.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_OB; i++) begin
            pos_d[i]  = pos_q[i];
            type_d[i] = type_q[i];
            if (step_now) begin
                if (pos_q[i] == 8'd0) begin
                    pos_d[i]  = POS_LAST;
                    type_d[i] = lfsr_q[1:0];
                end else begin
                    pos_d[i] = pos_q[i] - 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan: one channel per slot, SCAN_DIV cycles per slot.
    // ------------------------------------------------------------------
    logic [7:0]        cur_pos;
    logic [1:0]        cur_type;
    logic [7:0]        trail_pos;
    logic              wide;
    logic [DISP_W-1:0] occ;
    logic [DISP_H-1:0] row_mask;

    always_comb begin
        scan_d = scan_q + 1'b1;
        slot_d = slot_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end
    end

    always_comb begin
        cur_pos   = pos_q[slot_q];
        cur_type  = type_q[slot_q];
        wide      = (cur_type != T_POST);
        // Trailing column of a two-wide obstacle wraps round the track,
        // so an obstacle at TRACK_LEN-1 shows its tail at column 0.
        trail_pos = (cur_pos == POS_LAST) ? 8'd0 : cur_pos + 8'd1;

        // Comparing against each column index keeps only columns < DISP_W.
        occ = '0;
        for (int c = 0; c < DISP_W; c++) begin
            occ[c] = (cur_pos == 8'(c)) || (wide && (trail_pos == 8'(c)));
        end

        row_mask = '0;
        case (cur_type)
            T_BOX, T_POST: begin
                row_mask[0] = 1'b1;
                row_mask[1] = 1'b1;
            end
            T_HIGH_BIRD: row_mask[3] = 1'b1;
            T_LOW_BIRD:  row_mask[2] = 1'b1;
            default:     row_mask    = '0;
        endcase

        // Nothing visible: blank the row so no stray pixels light up.
        row_d = (occ == '0) ? '0 : row_mask;
        col_d = ~occ;
    end

    // ------------------------------------------------------------------
    // Registers. Restart wins over every other event, including a step.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (flag_restart) begin
            for (int i = 0; i < NUM_OB; i++) begin
                pos_q[i]  <= 8'(FIRST_POS + i * SPACING);
                type_q[i] <= 2'(i % 3);
            end
            lfsr_q     <= LFSR_SEED;
            div_q      <= '0;
            step_cnt_q <= '0;
            fast_q     <= 1'b0;
            tick_q     <= 1'b0;
            scan_q     <= '0;
            slot_q     <= '0;
            row_q      <= '0;
            col_q      <= '1;
        end else begin
            for (int i = 0; i < NUM_OB; i++) begin
                pos_q[i]  <= pos_d[i];
                type_q[i] <= type_d[i];
            end
            lfsr_q     <= lfsr_d;
            div_q      <= div_d;
            step_cnt_q <= step_cnt_d;
            fast_q     <= fast_d;
            tick_q     <= tick_d;
            scan_q     <= scan_d;
            slot_q     <= slot_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: direct register views
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_OB; i++) begin
            ob_pos[8*i +: 8]  = pos_q[i];
            ob_type[2*i +: 2] = type_q[i];
        end
    end

    assign row       = row_q;
    assign col       = col_q;
    assign step_tick = tick_q;
    assign fast_mode = fast_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Self-checking bench for obstacle_scroller with small step/scan periods.
// Latency: outputs sampled on the falling edge, inputs driven there too.
// Backpressure: none; every wait on the design is cycle-bounded.
module tb_obstacle_scroller;

    localparam int          DISP_W    = 16;
    localparam int          DISP_H    = 8;
    localparam int          TRACK_LEN = 51;
    localparam int          NUM_OB    = 3;
    localparam int          SCAN_DIV  = 2;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic                  clk = 1'b0;
    logic                  flag_restart;
    logic                  pause;
    logic [DISP_H-1:0]     row;
    logic [DISP_W-1:0]     col;
    logic [NUM_OB*8-1:0]   ob_pos;
    logic [NUM_OB*2-1:0]   ob_type;
    logic                  step_tick;
    logic                  fast_mode;

    always #5 clk = ~clk;

    obstacle_scroller #(
        .DISP_W      (DISP_W),
        .DISP_H      (DISP_H),
        .TRACK_LEN   (TRACK_LEN),
        .NUM_OB      (NUM_OB),
        .FIRST_POS   (13),
        .SPACING     (11),
        .STEP_SLOW   (4),
        .STEP_FAST   (2),
        .LEVEL_STEPS (3),
        .SCAN_DIV    (SCAN_DIV),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk          (clk),
        .flag_restart (flag_restart),
        .pause        (pause),
        .row          (row),
        .col          (col),
        .ob_pos       (ob_pos),
        .ob_type      (ob_type),
        .step_tick    (step_tick),
        .fast_mode    (fast_mode)
    );

    int checks;
    int errors;

    // Reference LFSR and cycle counter since the last restart edge.
    int          cyc;
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_prev;

    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        if (flag_restart) begin
            cyc    <= 0;
            lfsr_m <= SEED;
        end else begin
            cyc    <= cyc + 1;
            lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits for the next step_tick; gap is the number of clock edges taken.
    task automatic wait_tick(input string name, input int maxc, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!step_tick && gap < maxc);
        if (!step_tick) begin
            checks++;
            errors++;
            $display("FAIL %s: no step_tick within %0d cycles", name, maxc);
        end
    endtask

    // Waits until row/col show the given scan slot (row/col lag slot by 1).
    task automatic show_slot(input int s);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((((cyc - 1) / SCAN_DIV) % NUM_OB) != s) && n < 12);
    endtask

    function automatic logic [15:0] exp_col(input logic [1:0] t, input logic [7:0] p);
        logic [15:0] occ;
        logic [7:0]  tr;
        occ = 16'h0000;
        tr  = (p == 8'(TRACK_LEN - 1)) ? 8'd0 : p + 8'd1;
        if (p < 8'd16) occ[p[3:0]] = 1'b1;
        if (t != 2'd1 && tr < 8'd16) occ[tr[3:0]] = 1'b1;
        return ~occ;
    endfunction

    function automatic logic [7:0] exp_row(input logic [1:0] t, input logic [7:0] p);
        if (exp_col(t, p) == 16'hFFFF) return 8'h00;
        case (t)
            2'd0, 2'd1: return 8'h03;
            2'd2:       return 8'h08;
            default:    return 8'h04;
        endcase
    endfunction

    typedef struct {
        int         gap;
        logic       fast;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int         gap;
        logic [1:0] t0;
        int         s;

        // Expected state after steps 2..16 (hand-computed).
        tbl[0]  = '{4, 1'b0, 8'd11, 8'd22, 8'd33};
        tbl[1]  = '{4, 1'b1, 8'd10, 8'd21, 8'd32};
        tbl[2]  = '{2, 1'b1, 8'd9,  8'd20, 8'd31};
        tbl[3]  = '{2, 1'b1, 8'd8,  8'd19, 8'd30};
        tbl[4]  = '{2, 1'b1, 8'd7,  8'd18, 8'd29};
        tbl[5]  = '{2, 1'b1, 8'd6,  8'd17, 8'd28};
        tbl[6]  = '{2, 1'b1, 8'd5,  8'd16, 8'd27};
        tbl[7]  = '{2, 1'b1, 8'd4,  8'd15, 8'd26};
        tbl[8]  = '{2, 1'b1, 8'd3,  8'd14, 8'd25};
        tbl[9]  = '{2, 1'b1, 8'd2,  8'd13, 8'd24};
        tbl[10] = '{2, 1'b1, 8'd1,  8'd12, 8'd23};
        tbl[11] = '{2, 1'b1, 8'd0,  8'd11, 8'd22};
        tbl[12] = '{2, 1'b1, 8'd50, 8'd10, 8'd21};
        tbl[13] = '{2, 1'b1, 8'd49, 8'd9,  8'd20};
        tbl[14] = '{2, 1'b1, 8'd48, 8'd8,  8'd19};

        checks       = 0;
        errors       = 0;
        t0           = 2'd0;
        flag_restart = 1'b1;
        pause        = 1'b0;

        // ---- Reset held for two cycles ----
        @(negedge clk);
        @(negedge clk);
        chk("rst_pos",  ob_pos,    {8'd35, 8'd24, 8'd13});
        chk("rst_type", ob_type,   {2'd2, 2'd1, 2'd0});
        chk("rst_row",  row,       8'h00);
        chk("rst_col",  col,       16'hFFFF);
        chk("rst_tick", step_tick, 1'b0);
        chk("rst_fast", fast_mode, 1'b0);
        flag_restart = 1'b0;

        // ---- First period, hand-written: box at 13 in slot 0, post at 24 in slot 1 ----
        @(negedge clk);
        chk("c1_row",  row,       8'h03);
        chk("c1_col",  col,       16'h9FFF);
        chk("c1_tick", step_tick, 1'b0);
        @(negedge clk);
        chk("c2_col",  col,       16'h9FFF);
        @(negedge clk);
        chk("c3_row",  row,       8'h00);
        chk("c3_col",  col,       16'hFFFF);
        chk("c3_tick", step_tick, 1'b0);
        @(negedge clk);
        chk("step1_tick", step_tick, 1'b1);
        chk("step1_pos",  ob_pos,    {8'd35 - 8'd1, 8'd23, 8'd12});
        chk("step1_fast", fast_mode, 1'b0);

        // ---- Steps 2..16 from the table ----
        for (int k = 0; k < 15; k++) begin
            wait_tick("tbl_tick", 8, gap);
            chk($sformatf("tbl_gap_s%0d", k + 2),  gap,       tbl[k].gap);
            chk($sformatf("tbl_fast_s%0d", k + 2), fast_mode, tbl[k].fast);
            chk($sformatf("tbl_pos_s%0d", k + 2),  ob_pos,    {tbl[k].p2, tbl[k].p1, tbl[k].p0});
            if (k == 12) begin
                // Channel 0 just wrapped: respawn type comes from the LFSR.
                t0 = lfsr_prev[1:0];
                chk("wrap_type0",  ob_type[1:0], t0);
                chk("wrap_type12", ob_type[5:2], {2'd2, 2'd1});
                pause = 1'b1;
                show_slot(0);
                chk("wrap_row", row, exp_row(t0, 8'd50));
                chk("wrap_col", col, exp_col(t0, 8'd50));
                pause = 1'b0;
            end
        end

        // ---- Pause mid-period (one cycle into a two-cycle period) ----
        @(negedge clk);
        chk("prepause_tick", step_tick, 1'b0);
        pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            s = ((cyc - 1) / SCAN_DIV) % NUM_OB;
            chk("pause_tick", step_tick, 1'b0);
            chk("pause_pos",  ob_pos,    {8'd19, 8'd8, 8'd48});
            // Only channel 1 (post at 8) is visible.
            chk("pause_row",  row, (s == 1) ? 8'h03 : 8'h00);
            chk("pause_col",  col, (s == 1) ? 16'hFEFF : 16'hFFFF);
        end
        pause = 1'b0;
        wait_tick("resume_tick", 4, gap);
        chk("resume_gap", gap,    1);
        chk("resume_pos", ob_pos, {8'd18, 8'd7, 8'd47});

        // ---- Run channel 0 down to the visible edge (steps 18..49) ----
        for (int n = 18; n <= 49; n++) begin
            wait_tick("run_tick", 4, gap);
            chk("run_gap", gap, 2);
        end
        chk("edge15_pos",  ob_pos[7:0],  8'd15);
        chk("edge15_type", ob_type[1:0], t0);
        pause = 1'b1;
        show_slot(0);
        chk("edge15_row", row, exp_row(t0, 8'd15));
        chk("edge15_col", col, exp_col(t0, 8'd15));
        pause = 1'b0;
        wait_tick("edge14_tick", 4, gap);
        chk("edge14_pos", ob_pos[7:0], 8'd14);
        pause = 1'b1;
        show_slot(0);
        chk("edge14_row", row, exp_row(t0, 8'd14));
        chk("edge14_col", col, exp_col(t0, 8'd14));

        // ---- Restart on the same edge as a step ----
        pause = 1'b0;
        @(negedge clk);
        flag_restart = 1'b1;
        @(negedge clk);
        chk("rr_tick", step_tick, 1'b0);
        chk("rr_fast", fast_mode, 1'b0);
        chk("rr_pos",  ob_pos,    {8'd35, 8'd24, 8'd13});
        chk("rr_type", ob_type,   {2'd2, 2'd1, 2'd0});
        chk("rr_row",  row,       8'h00);
        chk("rr_col",  col,       16'hFFFF);
        flag_restart = 1'b0;
        wait_tick("rr_tick1", 8, gap);
        chk("rr_gap1", gap,       4);
        chk("rr_pos1", ob_pos,    {8'd34, 8'd23, 8'd12});
        chk("rr_fst1", fast_mode, 1'b0);
        wait_tick("rr_tick2", 8, gap);
        chk("rr_gap2", gap,       4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
